// File: rtl/event_sink_collector_pkg.sv
// Shared definitions for the event sink: filtered value width derivation and
// the memory-sequencer state encoding.
package event_sink_collector_pkg;

  localparam int VALUE_EXTRA_BITS = 12;

  function automatic int value_width(input int raw_width);
    return raw_width + VALUE_EXTRA_BITS;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

endpackage

// File: rtl/event_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and flush.
// A push into a full FIFO or a pop from an empty one is ignored.
module event_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/event_sink_collector.sv
// Event sink: buffers incoming pixel events, writes them into a single-port
// feature memory, serves readback requests and sweeps the memory on clear.
module event_sink_collector
  import event_sink_collector_pkg::*;
#(
  parameter int DATA_WIDTH     = 4,
  parameter int DATA_WIDTH_2   = value_width(DATA_WIDTH),
  parameter int FIFO_DEPTH     = 16,
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int IDLE_TIMEOUT   = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH_2-1:0]   in_event_value,
  input  logic [15:0]               in_event_addr,
  input  logic                      in_event_valid,
  output logic                      ready_for_new_event,
  input  logic                      rd_req,
  input  logic [MEM_ADDR_WIDTH-1:0] rd_addr,
  output logic                      rd_ready,
  output logic [DATA_WIDTH_2-1:0]   rd_data,
  output logic                      rd_valid,
  input  logic                      clear,
  output logic [31:0]               event_count,
  output logic                      overflow,
  output logic                      frame_done,
  output logic                      busy
);

  localparam int EW = DATA_WIDTH_2 + MEM_ADDR_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  state_t                    state, state_nxt;
  logic [EW-1:0]             fifo_rdata;
  logic [CW-1:0]             fifo_cnt, cnt_pending;
  logic                      fifo_full, fifo_empty;
  logic                      accept, writing, start_clear, rd_grant, frame_end;
  logic [MEM_ADDR_WIDTH-1:0] rd_addr_q, clr_addr, mem_addr;
  logic [DATA_WIDTH_2-1:0]   mem [2**MEM_ADDR_WIDTH];
  logic [DATA_WIDTH_2-1:0]   mem_q, mem_wdata;
  logic                      mem_we, have_data, seen;
  logic [TW-1:0]             idle_cnt;

  assign ready_for_new_event = !rst && !fifo_full && (state != ST_CLEAR);
  assign accept      = in_event_valid && ready_for_new_event;
  assign writing     = (state == ST_WRITE);
  assign start_clear = clear && (state != ST_CLEAR);
  assign busy        = (state == ST_CLEAR);
  assign rd_ready    = rd_grant && !rst;
  assign rd_data     = have_data ? mem_q : '0;

  // Entries still waiting after this cycle's pop, so a drain never overshoots.
  assign cnt_pending = fifo_cnt - CW'(writing);

  assign frame_end = seen && fifo_empty && !in_event_valid &&
                     (idle_cnt == TW'(IDLE_TIMEOUT - 1));

  event_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (start_clear),
    .push  (accept),
    .pop   (writing),
    .wdata ({in_event_value, in_event_addr[MEM_ADDR_WIDTH-1:0]}),
    .rdata (fifo_rdata),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nxt = ST_IDLE;
    rd_grant  = 1'b0;
    if (state == ST_CLEAR)                        state_nxt = (&clr_addr) ? ST_IDLE : ST_CLEAR;
    else if (clear)                               state_nxt = ST_CLEAR;
    else if (cnt_pending >= CW'(FIFO_DEPTH / 2))  state_nxt = ST_WRITE;
    else if (rd_req) begin
      state_nxt = ST_READ;
      rd_grant  = 1'b1;
    end
    else if (cnt_pending != '0)                   state_nxt = ST_WRITE;
  end

  always_comb begin
    mem_addr  = clr_addr;
    mem_wdata = '0;
    mem_we    = 1'b0;
    case (state)
      ST_WRITE: begin
        mem_addr  = fifo_rdata[MEM_ADDR_WIDTH-1:0];
        mem_wdata = fifo_rdata[EW-1 -: DATA_WIDTH_2];
        mem_we    = 1'b1;
      end
      ST_READ:  mem_addr = rd_addr_q;
      ST_CLEAR: mem_we   = 1'b1;
      default:  ;
    endcase
  end

  // Memory and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (state == ST_READ) mem_q <= mem[mem_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      rd_addr_q   <= '0;
      clr_addr    <= '0;
      rd_valid    <= 1'b0;
      have_data   <= 1'b0;
      event_count <= '0;
      overflow    <= 1'b0;
      frame_done  <= 1'b0;
      seen        <= 1'b0;
      idle_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      rd_valid   <= (state == ST_READ);
      frame_done <= 1'b0;
      if (rd_grant) rd_addr_q <= rd_addr;
      if (state == ST_READ) have_data <= 1'b1;
      clr_addr <= (state == ST_CLEAR) ? clr_addr + 1'b1 : '0;

      if (in_event_valid)                          idle_cnt <= '0;
      else if (idle_cnt != TW'(IDLE_TIMEOUT - 1))  idle_cnt <= idle_cnt + 1'b1;

      if (start_clear) begin
        event_count <= '0;
        overflow    <= 1'b0;
        seen        <= 1'b0;
      end else begin
        if (accept) begin
          event_count <= event_count + 1'b1;
          seen        <= 1'b1;
        end
        if (in_event_valid && !ready_for_new_event) overflow <= 1'b1;
        if (frame_end) begin
          frame_done <= 1'b1;
          seen       <= 1'b0;
        end
      end
    end
  end

endmodule
